// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   This is the multi-cycle HI/LO unit that sits in the EX stage beside the ALU.
//   It runs MULT/MULTU with a shift-add multiplier and DIV/DIVU with a restoring
//   divider, one bit per clock. It also owns the HI/LO registers and serves
//   MFHI/MFLO/MTHI/MTLO.
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   EX holds an R-type HI/LO instruction
//   funct   6-bit function code that selects the operation
//   rs_val  operand A, dividend, or MTHI/MTLO source
//   rt_val  operand B or divisor
//   hi      HI register (MFHI data)
//   lo      LO register (MFLO data)
//   busy    an operation is in flight
//   stall   a HI/LO instruction arrived while busy; the pipeline must hold EX
//   done    one-cycle pulse when a new HI/LO result becomes visible
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: the low half shifts dividend bits out and quotient bits in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] opb_q, opb_d;      // multiplicand or divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;      // operand signs differ (signed ops only)
  logic             rneg_q, rneg_d;    // dividend was negative
  logic             dz_q, dz_d;        // divisor was zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_arith, is_hilo, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH+1:0] dtrial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_arith  = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);
  assign is_hilo   = is_arith || (funct == F_MFHI) || (funct == F_MTHI) ||
                     (funct == F_MFLO) || (funct == F_MTLO);
  assign signed_op = (funct == F_MULT) || (funct == F_DIV);
  assign a_neg     = signed_op && rs_val[WIDTH-1];
  assign b_neg     = signed_op && rt_val[WIDTH-1];
  assign a_mag     = a_neg ? -rs_val : rs_val;
  assign b_mag     = b_neg ? -rt_val : rt_val;

  assign msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign dshift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign dtrial = {1'b0, dshift} - {2'b00, opb_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  // A zero divisor yields all-ones regardless of sign. The remainder then holds
  // |dividend|, and re-signing it restores rs_val exactly.
  assign quo_fix  = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  assign busy  = (state_q != S_IDLE);
  assign stall = busy && start && is_hilo;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_arith) begin
            is_div_d = (funct == F_DIV) || (funct == F_DIVU);
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = (rt_val == '0);
            cnt_d    = '0;
            rem_d    = '0;
            if ((funct == F_DIV) || (funct == F_DIVU)) begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              opb_d = b_mag;
            end else begin
              acc_d = {{WIDTH{1'b0}}, b_mag};
              opb_d = a_mag;
            end
            state_d = S_RUN;
          end else if (funct == F_MTHI) begin
            hi_d = rs_val;
          end else if (funct == F_MTLO) begin
            lo_d = rs_val;
          end
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          if (!dtrial[WIDTH+1]) begin
            rem_d = dtrial[WIDTH:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = dshift;
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (acc_q[0]) acc_d = {msum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W = 32;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [5:0]    funct;
  logic [W-1:0]  rs_val, rt_val, hi, lo;
  logic          busy, stall, done;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .stall (stall),
    .done  (done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          sc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {hi, lo}
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sbv, q, r;
    logic [63:0] res;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    res = '0;
    case (f)
      F_MULT:  res = sa * sbv;
      F_MULTU: res = {32'h0, a} * {32'h0, b};
      F_DIV: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else begin
          q   = sa / sbv;
          r   = sa % sbv;
          res = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending result
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_hi", hi, mon_e.hi);
        chk("sb_lo", lo, mon_e.lo);
        chk("sb_latency", cyc - mon_e.sc, 64'd33);
      end
    end
  end

  // Called at a falling edge; presents one start for one cycle, returns at the next falling edge
  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
    exp_t e;
    logic [63:0] m;
    start  = 1'b1;
    funct  = f;
    rs_val = a;
    rt_val = b;
    if (push) begin
      m    = model(f, a, b);
      e.hi = m[63:32];
      e.lo = m[31:0];
      e.sc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    funct = 6'h00;
  endtask

  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int nb, nd;
    bit held;
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    launch(f, a, b, 1'b1);
    nb = 0;
    nd = 0;
    held = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (busy) begin
        nb++;
        if (hi !== h0 || lo !== l0) held = 1'b0;
      end
      if (done) nd++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, 64'd33);
    chk("done_cycles", nd, 64'd1);
    chk("hold_during_run", held, 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", (k < 80), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  ftab [4];
    logic [63:0] m;
    logic [31:0] h0, ra, rb;
    int ns, k;
    ftab[0] = F_MULT; ftab[1] = F_MULTU; ftab[2] = F_DIV; ftab[3] = F_DIVU;

    reset = 1'b1; start = 1'b1; funct = F_MULT; rs_val = 32'h5; rt_val = 32'h3;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 64'd0);
    chk("rst_lo", lo, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_stall", stall, 64'd0);
    chk("rst_done", done, 64'd0);
    reset = 1'b0; start = 1'b0; funct = 6'h00;
    @(negedge clk);
    chk("idle_busy", busy, 64'd0);

    do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_max_hi", hi, 64'hFFFFFFFE);
    chk("multu_max_lo", lo, 64'h00000001);

    do_op(F_MULT, -32'sd3, 32'd7);
    chk("mult_neg_hi", hi, 64'hFFFFFFFF);
    chk("mult_neg_lo", lo, 64'hFFFFFFEB);

    do_op(F_DIV, -32'sd7, 32'd2);
    chk("div_neg_lo", lo, 64'hFFFFFFFD);
    chk("div_neg_hi", hi, 64'hFFFFFFFF);

    do_op(F_DIVU, 32'd100, 32'd7);
    chk("divu_lo", lo, 64'd14);
    chk("divu_hi", hi, 64'd2);

    do_op(F_DIVU, 32'd5, 32'd0);
    chk("divu_dz_lo", lo, 64'hFFFFFFFF);
    chk("divu_dz_hi", hi, 64'd5);

    do_op(F_DIV, 32'hFFFFFFFB, 32'd0);
    chk("div_dz_lo", lo, 64'hFFFFFFFF);
    chk("div_dz_hi", hi, 64'hFFFFFFFB);

    do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo", lo, 64'h80000000);
    chk("div_ovf_hi", hi, 64'd0);

    do_op(F_MULT, 32'h80000000, 32'h80000000);
    chk("mult_minmin_hi", hi, 64'h40000000);
    chk("mult_minmin_lo", lo, 64'd0);

    // MFLO held in EX during a MULT: stall until the done cycle
    m = model(F_MULT, 32'h00012345, 32'hFFFFFF00);
    launch(F_MULT, 32'h00012345, 32'hFFFFFF00, 1'b1);
    start = 1'b1; funct = F_MFLO;
    ns = 0;
    for (int i = 0; i < 33; i++) begin
      #1;
      if (stall) ns++;
      @(negedge clk);
    end
    #1;
    chk("stall_cycles", ns, 64'd33);
    chk("stall_in_done", stall, 64'd0);
    chk("done_with_mflo", done, 64'd1);
    chk("mflo_value", lo, {32'h0, m[31:0]});
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    @(negedge clk);

    // Junk funct does not stall; MTHI while busy stalls and is dropped
    launch(F_DIVU, 32'd1000, 32'd3, 1'b1);
    start = 1'b1; funct = 6'h20;
    #1;
    chk("junk_stall", stall, 64'd0);
    funct = F_MTHI; rs_val = 32'hDEAD;
    #1;
    chk("mthi_busy_stall", stall, 64'd1);
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    wait_idle();
    chk("mthi_dropped_hi", hi, 64'd1);

    // Reset sampled at edge 10 of a DIV
    launch(F_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy, 64'd0);
    chk("midrst_hi", hi, 64'd0);
    chk("midrst_lo", lo, 64'd0);
    chk("midrst_done", done, 64'd0);
    repeat (40) @(negedge clk);
    do_op(F_MULTU, 32'd6, 32'd7);
    chk("after_rst_lo", lo, 64'd42);
    chk("after_rst_hi", hi, 64'd0);

    // MTHI / MTLO while idle
    start = 1'b1; funct = F_MTHI; rs_val = 32'hCAFE;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    chk("mthi_hi", hi, 64'hCAFE);
    chk("mthi_lo_kept", lo, 64'd42);
    chk("mthi_no_done", done, 64'd0);
    h0 = hi;
    start = 1'b1; funct = F_MTLO; rs_val = 32'h1234;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    chk("mtlo_lo", lo, 64'h1234);
    chk("mtlo_hi_kept", hi, h0);
    chk("mtlo_no_done", done, 64'd0);
    @(negedge clk);
    chk("mtlo_no_done2", done, 64'd0);

    // Back-to-back: new MULT presented in the done cycle
    launch(F_MULT, 32'd9, -32'sd4, 1'b1);
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done_seen", done, 64'd1);
    launch(F_MULT, -32'sd100, -32'sd100, 1'b1);
    chk("b2b_busy", busy, 64'd1);
    wait_idle();
    chk("b2b_lo", lo, 64'd10000);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      if (i == 3)          rb = 32'h0;
      else if (i % 2 == 1) rb = $urandom;
      else                 rb = $urandom_range(1, 50);
      if (i == 5) ra = -ra;
      do_op(ftab[$urandom_range(0, 3)], ra, rb);
    end

    wait_idle();
    chk("sb_drained", sb.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
